// File: rtl/matrix_spi_driver.sv
// MAX7219 driver: one-time init sequence, then continuous refresh of eight row snapshots over SPI.
// Optional MATRIX_SPI_SKIP_UNCHANGED_EN: rows whose data equals the last value sent are skipped.
module matrix_spi_driver #(
   parameter int         DATAWIDTH_BUS = 8,
   parameter int         CLKDIV        = 4,
   parameter logic [3:0] INTENSITY     = 4'h8
) (
   input  logic                     SC_MATRIX_SPI_CLOCK_50,
   input  logic                     SC_MATRIX_SPI_RESET_InLow,
   input  logic                     SC_MATRIX_SPI_ENABLE_InHigh,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_0_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_1_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_2_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_3_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_4_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_5_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_6_In_Bus,
   input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SPI_ROW_7_In_Bus,
   output logic                     SC_MATRIX_SPI_DIN_Out,
   output logic                     SC_MATRIX_SPI_SCK_Out,
   output logic                     SC_MATRIX_SPI_LOAD_Out,
   output logic                     SC_MATRIX_SPI_BUSY_OutHigh,
   output logic                     SC_MATRIX_SPI_INIT_DONE_OutHigh,
   output logic                     SC_MATRIX_SPI_FRAME_DONE_OutHigh
);
   localparam int DIV_W = $clog2(CLKDIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

   typedef enum logic [2:0] {S_INIT, S_SNAP, S_SEND, S_DONE, S_IDLE} state_t;

   logic clk, rst_n, enable;
   assign clk    = SC_MATRIX_SPI_CLOCK_50;
   assign rst_n  = SC_MATRIX_SPI_RESET_InLow;
   assign enable = SC_MATRIX_SPI_ENABLE_InHigh;

   logic [DATAWIDTH_BUS-1:0] row_in [8];
   logic [DATAWIDTH_BUS-1:0] snap [8];
   assign row_in[0] = SC_MATRIX_SPI_ROW_0_In_Bus;
   assign row_in[1] = SC_MATRIX_SPI_ROW_1_In_Bus;
   assign row_in[2] = SC_MATRIX_SPI_ROW_2_In_Bus;
   assign row_in[3] = SC_MATRIX_SPI_ROW_3_In_Bus;
   assign row_in[4] = SC_MATRIX_SPI_ROW_4_In_Bus;
   assign row_in[5] = SC_MATRIX_SPI_ROW_5_In_Bus;
   assign row_in[6] = SC_MATRIX_SPI_ROW_6_In_Bus;
   assign row_in[7] = SC_MATRIX_SPI_ROW_7_In_Bus;

   state_t state, state_next;
   logic [3:0] idx, idx_next;
   logic init_done, init_set, snap_load;

   logic active, gap, half, din, sck, load, busy;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0] bit_cnt;
   logic [15:0] shreg, start_word;
   logic div_last, word_last, eng_ready, start;
   logic [3:0] sel_row, sel_addr;
   logic sel_found;

   // Word handshake: the FSM may raise start only while eng_ready is high; the word is
   // accepted on that clock edge, and eng_ready covers the last gap cycle so words abut.
   assign div_last  = (div_cnt == DIV_LAST);
   assign word_last = gap && half && div_last;
   assign eng_ready = !active && (!gap || word_last);
   assign sel_addr  = sel_row + 4'd1;

   function automatic logic [15:0] init_word(input logic [3:0] n);
      case (n)
         4'd0:    init_word = 16'h0F00;
         4'd1:    init_word = 16'h0900;
         4'd2:    init_word = {8'h0A, 4'h0, INTENSITY};
         4'd3:    init_word = 16'h0B07;
         default: init_word = 16'h0C01;
      endcase
   endfunction

`ifdef MATRIX_SPI_SKIP_UNCHANGED_EN
   logic [DATAWIDTH_BUS-1:0] shadow [8];
   logic [7:0] shadow_valid;

   // Lowest row at or after idx whose snapshot differs from what the panel already holds.
   always_comb begin
      sel_found = 1'b0;
      sel_row   = 4'd8;
      for (int r = 7; r >= 0; r--) begin
         if (4'(r) >= idx && (!shadow_valid[r] || shadow[r] != snap[r])) begin
            sel_found = 1'b1;
            sel_row   = 4'(r);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_valid <= '0;
         for (int i = 0; i < 8; i++) shadow[i] <= '0;
      end else if (start && state == S_SEND) begin
         shadow[sel_row[2:0]]       <= snap[sel_row[2:0]];
         shadow_valid[sel_row[2:0]] <= 1'b1;
      end
   end
`else
   always_comb begin
      sel_found = !idx[3];
      sel_row   = idx;
   end
`endif

   always_comb begin
      state_next = state;
      idx_next   = idx;
      start      = 1'b0;
      start_word = '0;
      snap_load  = 1'b0;
      init_set   = 1'b0;
      case (state)
         S_INIT: if (eng_ready) begin
            if (idx == 4'd5) begin
               state_next = S_SNAP;
               idx_next   = '0;
               init_set   = 1'b1;
            end else begin
               start      = 1'b1;
               start_word = init_word(idx);
               idx_next   = idx + 4'd1;
            end
         end
         S_SNAP: begin
            if (enable) begin
               snap_load  = 1'b1;
               idx_next   = '0;
               state_next = S_SEND;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_SEND: if (eng_ready) begin
            if (sel_found) begin
               start      = 1'b1;
               start_word = {4'b0000, sel_addr, snap[sel_row[2:0]]};
               idx_next   = sel_addr;
            end else begin
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_SNAP;
         S_IDLE:  if (enable) state_next = S_SNAP;
         default: state_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         idx       <= '0;
         init_done <= 1'b0;
         for (int i = 0; i < 8; i++) snap[i] <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (init_set) init_done <= 1'b1;
         if (snap_load) snap <= row_in;
      end
   end

   // Serializer: div_cnt paces half-bits, half selects SCK low/high, gap is the LOAD-high latch time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0; gap <= 1'b0; half <= 1'b0;
         div_cnt <= '0; bit_cnt <= '0; shreg <= '0;
         din <= 1'b0; sck <= 1'b0; load <= 1'b1; busy <= 1'b0;
      end else if (start) begin
         active <= 1'b1; gap <= 1'b0; half <= 1'b0;
         div_cnt <= '0; bit_cnt <= '0; shreg <= start_word;
         din <= start_word[15]; sck <= 1'b0; load <= 1'b0; busy <= 1'b1;
      end else if (active || gap) begin
         if (!div_last) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
            half    <= !half;
            if (gap) begin
               if (half) gap <= 1'b0;
            end else if (!half) begin
               sck <= 1'b1;
            end else begin
               sck     <= 1'b0;
               shreg   <= {shreg[14:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == 4'd15) begin
                  active <= 1'b0; gap <= 1'b1; load <= 1'b1; din <= 1'b0; busy <= 1'b0;
               end else begin
                  din <= shreg[14];
               end
            end
         end
      end
   end

   assign SC_MATRIX_SPI_DIN_Out            = din;
   assign SC_MATRIX_SPI_SCK_Out            = sck;
   assign SC_MATRIX_SPI_LOAD_Out           = load;
   assign SC_MATRIX_SPI_BUSY_OutHigh       = busy;
   assign SC_MATRIX_SPI_INIT_DONE_OutHigh  = init_done;
   assign SC_MATRIX_SPI_FRAME_DONE_OutHigh = (state == S_DONE);
endmodule

// File: tb/tb_matrix_spi_driver.sv
// Bench for matrix_spi_driver: expected SPI words are queued from a row-level model and a
// pin-level monitor decodes LOAD/SCK/DIN, checking word contents and timing.
module tb_matrix_spi_driver;
   localparam int CLKDIV      = 2;
   localparam int WORD_LOW    = 32 * CLKDIV;
   localparam int WORD_PERIOD = 34 * CLKDIV;
`ifdef MATRIX_SPI_SKIP_UNCHANGED_EN
   localparam int RAND_WAIT = 40;
`else
   localparam int RAND_WAIT = 400;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic [7:0] rows [8];
   logic din, sck, load, busy, init_done, frame_done;

   matrix_spi_driver #(.DATAWIDTH_BUS(8), .CLKDIV(CLKDIV), .INTENSITY(4'h8)) dut (
      .SC_MATRIX_SPI_CLOCK_50          (clk),
      .SC_MATRIX_SPI_RESET_InLow       (rst_n),
      .SC_MATRIX_SPI_ENABLE_InHigh     (enable),
      .SC_MATRIX_SPI_ROW_0_In_Bus      (rows[0]),
      .SC_MATRIX_SPI_ROW_1_In_Bus      (rows[1]),
      .SC_MATRIX_SPI_ROW_2_In_Bus      (rows[2]),
      .SC_MATRIX_SPI_ROW_3_In_Bus      (rows[3]),
      .SC_MATRIX_SPI_ROW_4_In_Bus      (rows[4]),
      .SC_MATRIX_SPI_ROW_5_In_Bus      (rows[5]),
      .SC_MATRIX_SPI_ROW_6_In_Bus      (rows[6]),
      .SC_MATRIX_SPI_ROW_7_In_Bus      (rows[7]),
      .SC_MATRIX_SPI_DIN_Out           (din),
      .SC_MATRIX_SPI_SCK_Out           (sck),
      .SC_MATRIX_SPI_LOAD_Out          (load),
      .SC_MATRIX_SPI_BUSY_OutHigh      (busy),
      .SC_MATRIX_SPI_INIT_DONE_OutHigh (init_done),
      .SC_MATRIX_SPI_FRAME_DONE_OutHigh(frame_done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   int exp_cnt_q[$];
   int total = 0;
   int bad = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model: what the panel should receive, expressed as words per frame.
   logic [7:0] shadow [8];
   logic [7:0] shadow_valid = '0;

   task automatic push_init();
      exp_q.push_back(16'h0F00);
      exp_q.push_back(16'h0900);
      exp_q.push_back(16'h0A08);
      exp_q.push_back(16'h0B07);
      exp_q.push_back(16'h0C01);
   endtask

   task automatic push_frame();
      int n = 0;
      for (int r = 0; r < 8; r++) begin
`ifdef MATRIX_SPI_SKIP_UNCHANGED_EN
         if (!shadow_valid[r] || shadow[r] != rows[r]) begin
`else
         begin
`endif
            exp_q.push_back({4'h0, 4'(r + 1), rows[r]});
            shadow[r] = rows[r];
            shadow_valid[r] = 1'b1;
            n++;
         end
      end
      exp_cnt_q.push_back(n);
   endtask

   // ---------------- monitor ----------------
   logic prev_load = 1'b1, prev_sck = 1'b0, prev_fd = 1'b0, prev_init = 1'b0;
   logic in_word = 1'b0, wave_ok = 1'b1, have_exp = 1'b0;
   logic [15:0] cur_exp = '0, shift_w = '0;
   int fall_cyc = 0, rise_cyc = 0, frame_start = 0, words_seen = 0, nrise = 0;
   int off, bit_i, n_exp;
   int idle_bad = 0, busy_bad = 0, fd_width_bad = 0, sticky_bad = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_word = 1'b0; prev_load = 1'b1; prev_sck = 1'b0; prev_fd = 1'b0; prev_init = 1'b0;
         words_seen = 0; nrise = 0;
      end else begin
         if (busy !== !load) busy_bad++;
         if (load && (sck !== 1'b0 || din !== 1'b0)) idle_bad++;
         if (prev_fd && frame_done) fd_width_bad++;
         if (prev_init && !init_done) sticky_bad++;
         if (prev_load && !load) begin
            in_word = 1'b1; fall_cyc = cyc; nrise = 0; shift_w = '0; wave_ok = 1'b1;
            if (words_seen == 0) frame_start = cyc;
            have_exp = (exp_q.size() > 0);
            cur_exp = have_exp ? exp_q[0] : 16'h0000;
            check("word_expected", have_exp, 1);
         end
         if (in_word && !load) begin
            off = cyc - fall_cyc;
            if (off < WORD_LOW) begin
               bit_i = off / (2 * CLKDIV);
               if (sck !== ((off % (2 * CLKDIV)) >= CLKDIV)) wave_ok = 1'b0;
               if (din !== cur_exp[15 - bit_i]) wave_ok = 1'b0;
            end
            if (sck && !prev_sck) begin
               shift_w = {shift_w[14:0], din};
               nrise++;
            end
         end
         if (in_word && load && !prev_load) begin
            in_word = 1'b0; rise_cyc = cyc; words_seen++;
            check("load_low_len", cyc - fall_cyc, WORD_LOW);
            check("sck_rises", nrise, 16);
            check("bit_timing", wave_ok, 1);
            if (have_exp) check("word", shift_w, exp_q.pop_front());
         end
         if (frame_done && !prev_fd) begin
            check("frame_done_expected", exp_cnt_q.size() > 0, 1);
            if (exp_cnt_q.size() > 0) begin
               n_exp = exp_cnt_q.pop_front();
               check("frame_words", words_seen, n_exp);
               if (n_exp > 0) begin
                  check("frame_len", cyc - frame_start, n_exp * WORD_PERIOD);
                  check("frame_done_after_gap", cyc - rise_cyc, 2 * CLKDIV);
               end
            end
            words_seen = 0;
         end
         if (init_done && !prev_init) begin
            check("init_words", words_seen, 5);
            check("init_len", cyc - frame_start, 5 * WORD_PERIOD);
            words_seen = 0;
         end
         prev_load = load; prev_sck = sck; prev_fd = frame_done; prev_init = init_done;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd(input int budget, input string name);
      int k = 0;
      do begin tick(); k++; end while (!frame_done && k < budget);
      check(name, frame_done, 1);
   endtask

   task automatic wait_init(input int budget, input string name);
      int k = 0;
      do begin tick(); k++; end while (!init_done && k < budget);
      check(name, init_done, 1);
   endtask

   task automatic wait_load_low(input int budget, input string name);
      int k = 0;
      do begin tick(); k++; end while (load && k < budget);
      check(name, load, 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_load"}, load, 1);
      check({tag, "_sck"}, sck, 0);
      check({tag, "_din"}, din, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_init_done"}, init_done, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_load"}, load, 1);
      check({tag, "_sck"}, sck, 0);
      check({tag, "_din"}, din, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k, j;
      for (int r = 0; r < 8; r++) rows[r] = 8'h00;
      repeat (3) tick();
      check_reset("por");
      rst_n = 1'b1;
      push_init();
      wait_load_low(4, "init_start");
      wait_init(1000, "init_done");
      repeat (100) tick();
      check_idle("idle_after_init");

      rows = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
      push_frame();
      enable = 1'b1;
      wait_load_low(4, "frame_start");

      for (int f = 0; f < 6; f++) begin
         if (f == 0) begin
            repeat (97) tick();
            rows[3] = 8'hFF;
         end else begin
            repeat ($urandom_range(5, RAND_WAIT)) tick();
            k = $urandom_range(0, 7);
            rows[k] = ~rows[k];
            if ($urandom_range(0, 1) == 1) begin
               j = (k + 1 + $urandom_range(0, 6)) % 8;
               rows[j] = 8'($urandom);
            end
         end
         if (f == 3) enable = 1'b0;
         wait_fd(1200, "frame_done_seen");
         if (f == 3) begin
            repeat (200) tick();
            check_idle("idle_after_disable");
            k = $urandom_range(0, 7);
            rows[k] = rows[k] ^ 8'h5A;
            push_frame();
            enable = 1'b1;
            wait_load_low(4, "reenable_start");
         end else begin
            push_frame();
         end
      end
      repeat (5) tick();
      enable = 1'b0;
      wait_fd(1200, "last_frame_done");
      repeat (50) tick();
      check_idle("idle_end_loop");

      // Reset in the middle of bit 7 of a word.
      for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
      push_frame();
      enable = 1'b1;
      k = 0;
      do begin tick(); k++; end while (!(in_word && nrise == 8) && k < 1200);
      check("reach_bit7", nrise, 8);
      rst_n = 1'b0;
      #1;
      check_reset("midword_rst");
      exp_q.delete();
      exp_cnt_q.delete();
      shadow_valid = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      push_init();
      push_frame();
      wait_load_low(4, "reinit_start");
      wait_init(1000, "reinit_done");
      repeat (10) tick();
      enable = 1'b0;
      wait_fd(1200, "post_reset_frame_done");
      repeat (50) tick();
      check_idle("idle_final");

      check("exp_q_drained", exp_q.size(), 0);
      check("exp_cnt_drained", exp_cnt_q.size(), 0);
      check("idle_levels_in_gaps", idle_bad, 0);
      check("busy_tracks_load", busy_bad, 0);
      check("frame_done_one_cycle", fd_width_bad, 0);
      check("init_done_sticky", sticky_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
